// File: rtl/sim_uart_pkg.sv
// Shared types and constants for the simulation UART input responder.
package sim_uart_pkg;

    typedef logic [7:0]  uart_ch_t;
    typedef logic [31:0] uart_cnt_t;

    localparam uart_ch_t UART_IDLE_CH = 8'hFF;

endpackage

// File: rtl/sim_uart_fifo.sv
// Byte FIFO with explicit occupancy tracking and naturally wrapping pointers.
module sim_uart_fifo
    import sim_uart_pkg::*;
#(
    parameter  int DEPTH = 16,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = AW + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push,
    input  uart_ch_t      push_ch,
    input  logic          pop,
    output uart_ch_t      head,
    output logic          full,
    output logic          empty,
    output logic [LW-1:0] level
);

    uart_ch_t      mem [DEPTH];
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;

    // Contents are not cleared by reset; the pointers alone define validity.
    always_ff @(posedge clock) begin
        if (push) begin
            mem[wptr] <= push_ch;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            wptr  <= '0;
            rptr  <= '0;
            level <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + AW'(1);
            end
            if (pop) begin
                rptr <= rptr + AW'(1);
            end
            case ({push, pop})
                2'b10:   level <= level + LW'(1);
                2'b01:   level <= level - LW'(1);
                default: level <= level;
            endcase
        end
    end

    assign head  = mem[rptr];
    assign full  = (level == LW'(DEPTH));
    assign empty = (level == '0);

endmodule

// File: rtl/sim_uart_in_responder.sv
// Answers SimTop's UART read strobes from a host-fed FIFO, with optional pacing.
module sim_uart_in_responder
    import sim_uart_pkg::*;
#(
    parameter  int       DEPTH    = 16,
    parameter  int       GAP      = 0,
    parameter  uart_ch_t EMPTY_CH = UART_IDLE_CH,
    localparam int       LW       = $clog2(DEPTH) + 1
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          push_valid,
    output logic          push_ready,
    input  uart_ch_t      push_ch,
    input  logic          io_uart_in_valid,
    output uart_ch_t      io_uart_in_ch,
    output uart_cnt_t     rx_count,
    output uart_cnt_t     underflow_count,
    output logic [LW-1:0] level
);

    localparam int GW = (GAP > 0) ? $clog2(GAP + 1) : 1;

    logic [GW-1:0] gap_cnt;
    logic          full;
    logic          empty;
    logic          deliverable;
    logic          push;
    logic          pop;
    logic          underflow;
    uart_ch_t      head;

    sim_uart_fifo #(
        .DEPTH (DEPTH)
    ) u_fifo (
        .clock   (clock),
        .reset   (reset),
        .push    (push),
        .push_ch (push_ch),
        .pop     (pop),
        .head    (head),
        .full    (full),
        .empty   (empty),
        .level   (level)
    );

    // The answer never looks at the strobe, so SimTop sees no comb loop.
    assign deliverable   = !empty && (gap_cnt == '0);
    assign push_ready    = !full;
    assign push          = push_valid && push_ready;
    assign pop           = io_uart_in_valid && deliverable;
    assign underflow     = io_uart_in_valid && !deliverable;
    assign io_uart_in_ch = deliverable ? head : EMPTY_CH;

    always_ff @(posedge clock) begin
        if (reset) begin
            gap_cnt         <= '0;
            rx_count        <= '0;
            underflow_count <= '0;
        end else begin
            if (pop) begin
                gap_cnt  <= GW'(GAP);
                rx_count <= rx_count + 32'd1;
            end else if (gap_cnt != '0) begin
                gap_cnt <= gap_cnt - GW'(1);
            end
            if (underflow) begin
                underflow_count <= underflow_count + 32'd1;
            end
        end
    end

endmodule

// File: doc/sim_uart_in_responder.md
# sim_uart_in_responder

Simulation-side responder for the SoC's UART input port. Whenever `SimTop` strobes `io_uart_in_valid` to read a character, this block answers with the next byte from an internal FIFO, or with the idle byte 0xFF when nothing is available. The host side, either a DPI loader or a plusarg-driven script feeder in `tb_top`, pushes bytes through a valid/ready interface. An optional inter-character gap emulates typing pace.

## Interface
Parameters:
- `DEPTH`, 16: FIFO entries; power of two, at least 2.
- `GAP`, 0: idle cycles enforced after each delivered byte; 0 disables pacing.
- `EMPTY_CH`, 8'hFF: byte returned when no character is deliverable.

Ports:
- `clock`  in  1  single clock for all logic.
- `reset`  in  1  synchronous, active-high.
- `push_valid`  in  1  host offers `push_ch`.
- `push_ready`  out  1  FIFO can accept a byte this cycle.
- `push_ch`  in  8  host byte.
- `io_uart_in_valid`  in  1  read strobe from `SimTop`.
- `io_uart_in_ch`  out  8  byte answered to `SimTop`.
- `rx_count`  out  32  bytes delivered to `SimTop`.
- `underflow_count`  out  32  strobes answered with `EMPTY_CH`.
- `level`  out  $clog2(DEPTH)+1  current FIFO occupancy.

## Operation
- **Deliverable**: `level != 0 && gap_cnt == 0`.
- **Output byte**: `io_uart_in_ch` equals the FIFO head when deliverable, otherwise `EMPTY_CH`. It is a combinational function of registers only; there is no path from `io_uart_in_valid`.
- **Pop**: `io_uart_in_valid && deliverable`. At the clock edge the read pointer advances, `rx_count` increments, and `gap_cnt` loads `GAP`.
- **Underflow**: `io_uart_in_valid && !deliverable`. `underflow_count` increments. The FIFO, `rx_count` and `gap_cnt` are unchanged.
- **Gap counter**: `gap_cnt` decrements by 1 each cycle while nonzero and saturates at 0.
- **Push**: `push_valid && push_ready`. The byte is written at the write pointer and the write pointer advances.
- **`push_ready`**: equals `level != DEPTH`. It is computed from registered state only and does not depend on a same-cycle pop.
- **Pointers**: `$clog2(DEPTH)` bits each and wrap naturally modulo `DEPTH`. `level` is tracked explicitly and updates by +1, -1 or 0 according to push/pop.
- **Counters**: 32-bit, wrap modulo 2^32 with no saturation.
- **Simultaneous events**:
  - Push and pop in the same cycle, FIFO non-empty and not full: both happen and `level` is unchanged.
  - Full and pop in the same cycle: the pop happens, no push is accepted (`push_ready` was 0), and `level` becomes `DEPTH-1`.
  - Empty and push and strobe in the same cycle: the strobe is an underflow answered `EMPTY_CH`, the byte is written, `level` becomes 1, and the byte is deliverable next cycle (if `gap_cnt == 0`).
- **Reset**: reset has priority over all other activity, including mid-stream. It clears the pointers, `level`, `gap_cnt` and both counters. FIFO contents are discarded; the memory itself need not be cleared.

## Timing
- Reset values:
  - `push_ready` = 1.
  - `io_uart_in_ch` = `EMPTY_CH`.
  - `rx_count` = 0.
  - `underflow_count` = 0.
  - `level` = 0.
- Push-to-visible latency: a byte accepted at edge N is on `io_uart_in_ch` from cycle N+1, if `gap_cnt` is 0.
- Pop at edge N:
  - With `GAP = G > 0`: `io_uart_in_ch` shows `EMPTY_CH` for cycles N+1 … N+G, and the next byte appears at cycle N+G+1.
  - With `GAP = 0`: back-to-back strobes deliver consecutive bytes, one per cycle.
- Counters and `level` reflect an event one cycle after its edge, since they are registered.

## Structure
- Package `sim_uart_pkg`:
  - typedef `uart_ch_t` (8-bit).
  - localparam `UART_IDLE_CH = 8'hFF`, used as the default for `EMPTY_CH`.
  - typedef `uart_cnt_t` (32-bit).
- Sub-module `sim_uart_fifo`:
  - parameterised by `DEPTH`.
  - owns the memory, pointers and `level`.
  - exposes `full`, `empty`, `head`, `push` and `pop`.
- The top level holds the gap counter, deliverable/underflow decode, output mux and statistics counters.

## Test plan
- **Idle after reset**: no pushes, strobe on 3 cycles → `io_uart_in_ch` = 0xFF throughout; `underflow_count` = 3, `rx_count` = 0.
- **Ordered delivery**: push 0x68, 0x69, 0x0A, then strobe 3 consecutive cycles with `GAP = 0` → bytes 0x68, 0x69, 0x0A in order; `rx_count` = 3; `level` = 0.
- **Full and wrap**: `DEPTH = 4`, push 0x01–0x04 → `push_ready` = 0. Offer 0x05 in the same cycle as a pop → 0x05 is rejected and `level` = 3. Push 0x05 next cycle → accepted. Drain yields 0x02, 0x03, 0x04, 0x05 across the pointer wrap.
- **Pacing**: `GAP = 2`, queue 0x41, 0x42, strobe every cycle → sequence 0x41, FF, FF, 0x42; `underflow_count` = 2.
- **Empty same-cycle**: `level` = 0, push 0x55 and strobe together → answer 0xFF and one underflow; the next-cycle strobe returns 0x55.
- **Reset mid-stream**: 3 bytes queued and `rx_count` = 5, assert `reset` for 1 cycle → next cycle `level` = 0, counters = 0, `io_uart_in_ch` = 0xFF, `push_ready` = 1.
